// File: rtl/kanagawa_race_monitor_pkg.sv
// Shared types and constants for the race monitor.
//   race_report_t  : one report record at the default widths
//                    (8-bit race count, 32-bit lifetime total)
//   report_state_t : report handshake FSM encoding
//   sat_inc_drop   : saturating increment for the dropped-record counter
package kanagawa_race_monitor_pkg;

  localparam int RACE_WINDOW_INDEX_WIDTH = 16;
  localparam int RACE_DROP_COUNT_WIDTH   = 8;
  localparam int RACE_COUNTER_WIDTH      = 8;
  localparam int RACE_TOTAL_WIDTH        = 32;

  typedef struct packed {
    logic [RACE_WINDOW_INDEX_WIDTH-1:0] window;
    logic [RACE_COUNTER_WIDTH-1:0]      delta;
    logic [RACE_TOTAL_WIDTH-1:0]        total;
    logic                               saturated;
  } race_report_t;

  typedef enum logic {
    REPORT_EMPTY   = 1'b0,
    REPORT_PENDING = 1'b1
  } report_state_t;

  function automatic logic [RACE_DROP_COUNT_WIDTH-1:0] sat_inc_drop(
    input logic [RACE_DROP_COUNT_WIDTH-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/kanagawa_race_window_timer.sv
// Sampling-window timer for the race monitor.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   enable        : 1 = timer advances, 0 = timer holds
//   window_close  : single-cycle strobe, high in the last enabled cycle of a window
module kanagawa_race_window_timer #(
  parameter int WINDOW_CYCLES = 128
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic window_close
);

  localparam int TIMER_WIDTH = $clog2(WINDOW_CYCLES);
  localparam logic [TIMER_WIDTH-1:0] LAST_CYCLE = TIMER_WIDTH'(WINDOW_CYCLES - 1);

  logic [TIMER_WIDTH-1:0] timer_q;

  // The close strobe depends on enable so a frozen timer sitting on the last
  // count does not keep closing windows.
  assign window_close = enable && (timer_q == LAST_CYCLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else if (window_close) begin
      timer_q <= '0;
    end else if (enable) begin
      timer_q <= timer_q + 1'b1;
    end
  end

endmodule

// File: rtl/kanagawa_race_monitor.sv
// Race monitor: turns the upstream wrapping race count into one report per
// window (race cycles in the window, saturating lifetime total), keeps a
// sticky threshold alarm and counts reports dropped for lack of a consumer.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   enable_in             : 1 = windows advance, 0 = timer frozen
//   race_count_in         : wrapping race count from upstream
//   alarm_clear_in        : pulse clearing the sticky alarm
//   report_valid_out/report_ready_in : report record handshake
//   report_window_out, report_delta_out, report_total_out,
//   report_saturated_out  : report record fields
//   alarm_out             : sticky alarm
//   dropped_count_out     : saturating count of dropped records
//
// Handshake: a record is transferred on any cycle where report_valid_out and
// report_ready_in are both 1. While valid is 1 and ready is 0 the record
// fields hold. Valid never depends combinationally on ready.
module kanagawa_race_monitor
  import kanagawa_race_monitor_pkg::*;
#(
  parameter int COUNTER_WIDTH = 8,
  parameter int WINDOW_CYCLES = 128,
  parameter int TOTAL_WIDTH   = 32,
  parameter int THRESHOLD     = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable_in,
  input  logic [COUNTER_WIDTH-1:0]           race_count_in,
  input  logic                               alarm_clear_in,
  output logic                               report_valid_out,
  input  logic                               report_ready_in,
  output logic [RACE_WINDOW_INDEX_WIDTH-1:0] report_window_out,
  output logic [COUNTER_WIDTH-1:0]           report_delta_out,
  output logic [TOTAL_WIDTH-1:0]             report_total_out,
  output logic                               report_saturated_out,
  output logic                               alarm_out,
  output logic [RACE_DROP_COUNT_WIDTH-1:0]   dropped_count_out
);

  localparam logic [COUNTER_WIDTH:0] THRESH = (COUNTER_WIDTH + 1)'(THRESHOLD);

  typedef struct packed {
    logic [RACE_WINDOW_INDEX_WIDTH-1:0] window;
    logic [COUNTER_WIDTH-1:0]           delta;
    logic [TOTAL_WIDTH-1:0]             total;
    logic                               saturated;
  } record_t;

  logic                               window_close;
  logic [COUNTER_WIDTH-1:0]           prev_q;
  logic [COUNTER_WIDTH-1:0]           delta;
  logic [TOTAL_WIDTH:0]               total_sum;
  logic [TOTAL_WIDTH-1:0]             total_q;
  logic [TOTAL_WIDTH-1:0]             total_next;
  logic [RACE_WINDOW_INDEX_WIDTH-1:0] window_q;
  logic [RACE_DROP_COUNT_WIDTH-1:0]   dropped_q;
  logic                               alarm_q;
  logic                               alarm_set;
  record_t                            rec_q;
  report_state_t                      state_q, state_d;
  logic                               accept;
  logic                               load;

  kanagawa_race_window_timer #(
    .WINDOW_CYCLES (WINDOW_CYCLES)
  ) u_window_timer (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable_in),
    .window_close (window_close)
  );

  // Modular subtraction is exact: at most one increment per cycle and a
  // window is shorter than the count's wrap period.
  assign delta      = race_count_in - prev_q;
  assign total_sum  = {1'b0, total_q} + (TOTAL_WIDTH + 1)'(delta);
  assign total_next = total_sum[TOTAL_WIDTH] ? '1 : total_sum[TOTAL_WIDTH-1:0];
  assign alarm_set  = (THRESHOLD != 0) && window_close && ({1'b0, delta} >= THRESH);

  assign accept = (state_q == REPORT_PENDING) && report_ready_in;
  // A close loads a new record unless an unaccepted one is still pending.
  assign load   = window_close && ((state_q == REPORT_EMPTY) || accept);

  always_comb begin
    state_d = state_q;
    if (window_close) begin
      state_d = REPORT_PENDING;
    end else if (accept) begin
      state_d = REPORT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= REPORT_EMPTY;
      prev_q    <= '0;
      total_q   <= '0;
      window_q  <= '0;
      dropped_q <= '0;
      alarm_q   <= 1'b0;
      rec_q     <= '0;
    end else begin
      state_q <= state_d;
      // While disabled, prev tracks the live count so races in a disabled
      // period never appear in a later window.
      if (window_close || !enable_in) begin
        prev_q <= race_count_in;
      end
      if (window_close) begin
        total_q  <= total_next;
        window_q <= window_q + 1'b1;
        if (!load) begin
          dropped_q <= sat_inc_drop(dropped_q);
        end
      end
      if (load) begin
        rec_q.window    <= window_q;
        rec_q.delta     <= delta;
        rec_q.total     <= total_next;
        rec_q.saturated <= (total_next == '1);
      end
      if (alarm_set) begin
        alarm_q <= 1'b1;
      end else if (alarm_clear_in) begin
        alarm_q <= 1'b0;
      end
    end
  end

  assign report_valid_out     = (state_q == REPORT_PENDING);
  assign report_window_out    = rec_q.window;
  assign report_delta_out     = rec_q.delta;
  assign report_total_out     = rec_q.total;
  assign report_saturated_out = rec_q.saturated;
  assign alarm_out            = alarm_q;
  assign dropped_count_out    = dropped_q;

endmodule

// File: tb/tb_kanagawa_race_monitor.sv
// Bench for kanagawa_race_monitor: two instances share stimulus, one with the
// default 32-bit total and one with an 8-bit total to reach saturation.
// A reference model built on unbounded integer counts predicts every output
// after every clock edge; directed phases follow the test plan, then random
// stimulus runs.
module tb_kanagawa_race_monitor;
  import kanagawa_race_monitor_pkg::*;

  localparam int WIN    = 128;
  localparam int THRESH = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        enable_in      = 1'b0;
  logic [7:0]  race_count_in  = '0;
  logic        alarm_clear_in = 1'b0;
  logic        report_ready_in = 1'b0;

  logic        valid_a, sat_a, alarm_a;
  logic [15:0] window_a;
  logic [7:0]  delta_a, dropped_a;
  logic [31:0] total_a;

  logic        valid_b, sat_b, alarm_b;
  logic [15:0] window_b;
  logic [7:0]  delta_b, dropped_b;
  logic [7:0]  total_b;

  kanagawa_race_monitor #(
    .COUNTER_WIDTH (8), .WINDOW_CYCLES (WIN), .TOTAL_WIDTH (32), .THRESHOLD (THRESH)
  ) dut (
    .clk (clk), .rst (rst), .enable_in (enable_in), .race_count_in (race_count_in),
    .alarm_clear_in (alarm_clear_in), .report_valid_out (valid_a),
    .report_ready_in (report_ready_in), .report_window_out (window_a),
    .report_delta_out (delta_a), .report_total_out (total_a),
    .report_saturated_out (sat_a), .alarm_out (alarm_a), .dropped_count_out (dropped_a)
  );

  kanagawa_race_monitor #(
    .COUNTER_WIDTH (8), .WINDOW_CYCLES (WIN), .TOTAL_WIDTH (8), .THRESHOLD (THRESH)
  ) dut_sat (
    .clk (clk), .rst (rst), .enable_in (enable_in), .race_count_in (race_count_in),
    .alarm_clear_in (alarm_clear_in), .report_valid_out (valid_b),
    .report_ready_in (report_ready_in), .report_window_out (window_b),
    .report_delta_out (delta_b), .report_total_out (total_b),
    .report_saturated_out (sat_b), .alarm_out (alarm_b), .dropped_count_out (dropped_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int           cnt = 0;          // upstream race count, never wraps here
  int           m_timer = 0;      // enabled cycles elapsed in current window
  int           m_last_ref = 0;   // count value the current window measures from
  int           m_win_idx = 0;
  longint       m_total = 0;
  longint       m_total8 = 0;
  bit           m_alarm = 1'b0;
  int           m_dropped = 0;
  bit           m_pend = 1'b0;
  race_report_t m_rec = '0;
  longint       m_rec_total8 = 0;
  bit           m_rec_sat8 = 1'b0;

  task automatic model_step();
    bit     accept;
    int     d;
    longint max32;
    max32 = 64'hFFFF_FFFF;
    if (rst) begin
      m_timer = 0; m_last_ref = 0; m_win_idx = 0; m_total = 0; m_total8 = 0;
      m_alarm = 0; m_dropped = 0; m_pend = 0; m_rec = '0; m_rec_total8 = 0; m_rec_sat8 = 0;
      return;
    end
    accept = m_pend && report_ready_in;
    if (enable_in && m_timer == WIN - 1) begin
      d = cnt - m_last_ref;
      m_last_ref = cnt;
      m_timer = 0;
      m_total  = (m_total + d > max32) ? max32 : m_total + d;
      m_total8 = (m_total8 + d > 255) ? 255 : m_total8 + d;
      if (d >= THRESH) m_alarm = 1;
      else if (alarm_clear_in) m_alarm = 0;
      if (!m_pend || accept) begin
        m_rec.window    = 16'(m_win_idx % 65536);
        m_rec.delta     = 8'(d);
        m_rec.total     = 32'(m_total);
        m_rec.saturated = (m_total == max32);
        m_rec_total8    = m_total8;
        m_rec_sat8      = (m_total8 == 255);
      end else begin
        if (m_dropped < 255) m_dropped++;
      end
      m_pend = 1;
      m_win_idx++;
    end else begin
      if (enable_in) m_timer++;
      else m_last_ref = cnt;
      if (alarm_clear_in) m_alarm = 0;
      if (accept) m_pend = 0;
    end
  endtask

  task automatic compare_all();
    check("valid",     longint'(valid_a),   longint'(m_pend));
    check("window",    longint'(window_a),  longint'(m_rec.window));
    check("delta",     longint'(delta_a),   longint'(m_rec.delta));
    check("total",     longint'(total_a),   longint'(m_rec.total));
    check("saturated", longint'(sat_a),     longint'(m_rec.saturated));
    check("alarm",     longint'(alarm_a),   longint'(m_alarm));
    check("dropped",   longint'(dropped_a), longint'(m_dropped));
    check("valid8",    longint'(valid_b),   longint'(m_pend));
    check("total8",    longint'(total_b),   m_rec_total8);
    check("saturated8",longint'(sat_b),     longint'(m_rec_sat8));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    race_count_in = 8'(cnt);
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; cnt = 0;
    for (int i = 0; i < n; i++) cycle();
    rst = 1'b0;
  endtask

  task automatic accept_one();
    report_ready_in = 1'b1;
    cycle();
    report_ready_in = 1'b0;
  endtask

  // Runs enabled until the current window closes; incs increments occur in
  // the first cycles of the window.
  task automatic window(input int incs, input bit clear_at_close, input bit ready_at_close);
    int rem;
    rem = WIN - m_timer;
    enable_in = 1'b1;
    for (int i = 0; i < rem; i++) begin
      if (i < incs) cnt++;
      alarm_clear_in  = clear_at_close && (i == rem - 1);
      report_ready_in = (i == rem - 1) ? ready_at_close : 1'b0;
      cycle();
    end
    alarm_clear_in  = 1'b0;
    report_ready_in = 1'b0;
  endtask

  initial begin
    // reset state
    enable_in = 1'b1;
    do_reset(3);
    check("rst_valid", longint'(valid_a), 0);
    check("rst_total", longint'(total_a), 0);
    check("rst_alarm", longint'(alarm_a), 0);

    // idle window: count held at 0
    window(0, 0, 0);
    check("w0_valid", longint'(valid_a), 1);
    check("w0_window", longint'(window_a), 0);
    check("w0_delta", longint'(delta_a), 0);
    accept_one();
    check("w0_accepted", longint'(valid_a), 0);

    // wrap: 250 -> 4 within one window
    enable_in = 1'b0; cnt = 250;
    cycle();
    window(10, 0, 0);
    check("wrap_delta", longint'(delta_a), 10);
    check("wrap_total", longint'(total_a), 10);
    accept_one();

    // alarm set, clear, and set-wins-over-clear
    window(16, 0, 0);
    check("alarm_set", longint'(alarm_a), 1);
    accept_one();
    alarm_clear_in = 1'b1;
    cycle();
    alarm_clear_in = 1'b0;
    check("alarm_cleared", longint'(alarm_a), 0);
    window(20, 1, 0);
    check("alarm_set_wins", longint'(alarm_a), 1);
    accept_one();

    // back-pressure: three closes with ready low, then close with ready
    window(3, 0, 0);
    window(5, 0, 0);
    window(7, 0, 0);
    check("held_delta", longint'(delta_a), 3);
    check("held_dropped", longint'(dropped_a), 2);
    window(9, 0, 1);
    check("reload_delta", longint'(delta_a), 9);
    check("reload_total", longint'(total_a), 70);
    check("reload_dropped", longint'(dropped_a), 2);
    accept_one();

    // saturation on the 8-bit total
    do_reset(2);
    window(100, 0, 0); accept_one();
    window(100, 0, 0); check("sat_total2", longint'(total_b), 200); accept_one();
    window(100, 0, 0);
    check("sat_total3", longint'(total_b), 255);
    check("sat_flag3", longint'(sat_b), 1);
    check("wide_total3", longint'(total_a), 300);
    accept_one();

    // disabled period: 50 races never reported
    enable_in = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i % 6 == 0) cnt++;
      cycle();
    end
    check("disabled_no_report", longint'(valid_a), 0);
    window(4, 0, 0);
    check("reenable_delta", longint'(delta_a), 4);

    // reset mid-window with a record pending
    enable_in = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cnt++;
      cycle();
    end
    do_reset(2);
    check("midrst_valid", longint'(valid_a), 0);
    check("midrst_total", longint'(total_a), 0);
    check("midrst_alarm", longint'(alarm_a), 0);

    // random stimulus
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1500) == 0) begin
        rst = 1'b1; cnt = 0;
      end else begin
        rst = 1'b0;
        if ($urandom_range(0, 2) == 0) cnt++;
      end
      enable_in       = ($urandom_range(0, 15) != 0);
      report_ready_in = $urandom_range(0, 1) != 0;
      alarm_clear_in  = ($urandom_range(0, 40) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
